// File: rtl/piso_shift_transmitter_pkg.sv
// Shared types and helpers for the PISO shift transmitter.
package piso_pkg;

  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} piso_state_t;

  // Even parity: the parity bit is the XOR of the data bits, optionally inverted by this constant.
  localparam logic PARITY_EVEN = 1'b0;

  // Bit counter width large enough to hold the value WIDTH.
  function automatic int cnt_w(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/piso_shift_transmitter_if.sv
// Word handshake and serial output bundle for the PISO shift transmitter.
interface piso_shift_transmitter_if #(
  parameter int WIDTH = 4
) ();

  logic             din_valid;
  logic [WIDTH-1:0] din;
  logic             din_ready;
  logic             sout;
  logic             sout_valid;
  logic             last;
  logic             busy;

  // Upstream word source / serial sink side.
  modport master (
    output din_valid, din,
    input  din_ready, sout, sout_valid, last, busy
  );

  // Transmitter side.
  modport slave (
    input  din_valid, din,
    output din_ready, sout, sout_valid, last, busy
  );

endinterface

// File: rtl/piso_shift_transmitter_core.sv
// Loadable shift register, bit down-counter and end-of-frame flag.
// Optional macro PISO_PARITY_EN appends an even-parity bit to every frame.
module piso_shift_core
  import piso_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             load,
  input  logic             in_shift,
  input  logic [WIDTH-1:0] din,
  output logic             sout,
  output logic             last
);

`ifdef PISO_PARITY_EN
  localparam int NBITS = WIDTH + 1;
`else
  localparam int NBITS = WIDTH;
`endif
  localparam int CW = cnt_w(WIDTH);

  logic [NBITS-1:0] frame;
  logic [NBITS-2:0] sreg;
  logic [CW-1:0]    cnt;

  // Arrange the outgoing frame so that bit NBITS-1 is transmitted first.
  always_comb begin
    frame = '0;
    for (int i = 0; i < WIDTH; i++) begin
      frame[NBITS-1-i] = MSB_FIRST ? din[WIDTH-1-i] : din[i];
    end
`ifdef PISO_PARITY_EN
    frame[0] = (^din) ^ PARITY_EVEN;
`endif
  end

  // Load a fresh frame on accept, otherwise shift one bit per cycle until the final bit.
  // On the final bit with no new word everything holds, so sout keeps its last value.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sout <= 1'b0;
      sreg <= '0;
      cnt  <= '0;
    end else if (load) begin
      sout <= frame[NBITS-1];
      sreg <= frame[NBITS-2:0];
      cnt  <= CW'(NBITS - 1);
    end else if (in_shift && !last) begin
      sout <= sreg[NBITS-2];
      sreg <= sreg << 1;
      cnt  <= cnt - CW'(1);
    end
  end

  assign last = in_shift && (cnt == '0);

endmodule

// File: rtl/piso_shift_transmitter.sv
// Parallel-in serial-out transmitter: FSM and valid/ready handshake around piso_shift_core.
// Optional macro PISO_PARITY_EN (handled in the core) adds a trailing even-parity bit.
module piso_shift_transmitter
  import piso_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                    clock,
  input  logic                    reset_n,
  piso_shift_transmitter_if.slave bus
);

  piso_state_t state_q, state_d;
  logic        last_w;
  logic        ready_w;
  logic        accept;

  // Ready in IDLE and on the final bit, so a new word can follow with no bubble.
  assign ready_w = (state_q == IDLE) || last_w;
  assign accept  = bus.din_valid && ready_w;

  // State register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: start a frame on accept, leave SHIFT only after a final bit with no new word.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = SHIFT;
      SHIFT:   if (last_w && !accept) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  piso_shift_core #(
    .WIDTH     (WIDTH),
    .MSB_FIRST (MSB_FIRST)
  ) u_core (
    .clock    (clock),
    .reset_n  (reset_n),
    .load     (accept),
    .in_shift (state_q == SHIFT),
    .din      (bus.din),
    .sout     (bus.sout),
    .last     (last_w)
  );

  assign bus.din_ready  = ready_w;
  assign bus.last       = last_w;
  assign bus.sout_valid = (state_q == SHIFT);
  assign bus.busy       = (state_q == SHIFT);

endmodule

// File: tb/tb_piso_shift_transmitter.sv
// Self-checking bench: an MSB-first and an LSB-first transmitter driven with identical words.
module tb_piso_shift_transmitter;

`ifdef PISO_PARITY_EN
  localparam int NB = 5;
`else
  localparam int NB = 4;
`endif

  logic clock;
  logic reset_n;
  int   checks   = 0;
  int   failures = 0;
  int   run_a    = 0;
  int   max_run  = 0;
  int   w        = 0;
  logic [1:0] qa[$];
  logic [1:0] qb[$];
  logic [1:0] ea_e, eb_e;

  typedef struct {
    logic [3:0] din;
    logic [3:0] ea;  // MSB-first bit order, element [3] sent first
    logic [3:0] eb;  // LSB-first bit order, element [3] sent first
  } vec_t;
  vec_t vecs[6];

  piso_shift_transmitter_if #(.WIDTH(4)) ifa ();
  piso_shift_transmitter_if #(.WIDTH(4)) ifb ();

  piso_shift_transmitter #(.WIDTH(4), .MSB_FIRST(1'b1)) ua (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (ifa)
  );

  piso_shift_transmitter #(.WIDTH(4), .MSB_FIRST(1'b0)) ub (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (ifb)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Scoreboard: pop one expected {bit,last} per valid serial cycle.
  always @(negedge clock) begin
    if (reset_n) begin
      if (ifa.sout_valid) begin
        checks++;
        if (qa.size() == 0) begin
          failures++;
          $display("FAIL a_unexpected_bit actual=%0b required=no valid bit", ifa.sout);
        end else begin
          ea_e = qa.pop_front();
          if ({ifa.sout, ifa.last} !== ea_e) begin
            failures++;
            $display("FAIL a_bit actual={%0b,%0b} required={%0b,%0b}", ifa.sout, ifa.last, ea_e[1], ea_e[0]);
          end
        end
        run_a++;
        if (run_a > max_run) max_run = run_a;
      end else begin
        run_a = 0;
      end
      if (ifb.sout_valid) begin
        checks++;
        if (qb.size() == 0) begin
          failures++;
          $display("FAIL b_unexpected_bit actual=%0b required=no valid bit", ifb.sout);
        end else begin
          eb_e = qb.pop_front();
          if ({ifb.sout, ifb.last} !== eb_e) begin
            failures++;
            $display("FAIL b_bit actual={%0b,%0b} required={%0b,%0b}", ifb.sout, ifb.last, eb_e[1], eb_e[0]);
          end
        end
      end
    end
  end

  // Offer a word to both DUTs (called at posedge+1); pushes expected bits when accepted.
  task automatic send(input logic [3:0] d, input logic [3:0] ea, input logic [3:0] eb, output int waits);
    waits = 0;
    ifa.din_valid = 1'b1; ifa.din = d;
    ifb.din_valid = 1'b1; ifb.din = d;
    while (!ifa.din_ready && waits < 50) begin
      @(posedge clock); #1;
      waits++;
    end
    if (!ifa.din_ready) begin
      checks++; failures++;
      $display("FAIL accept_timeout actual=not ready required=ready");
    end else begin
      for (int k = 3; k >= 0; k--) begin
        qa.push_back({ea[k], (NB == 4) && (k == 0)});
        qb.push_back({eb[k], (NB == 4) && (k == 0)});
      end
`ifdef PISO_PARITY_EN
      qa.push_back({^d, 1'b1});
      qb.push_back({^d, 1'b1});
`endif
      @(posedge clock); #1;
    end
    ifa.din_valid = 1'b0; ifa.din = 4'($urandom);
    ifb.din_valid = 1'b0; ifb.din = ifa.din;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((ifa.sout_valid || ifb.sout_valid) && n < 40) begin
      @(posedge clock); #1;
      n++;
    end
    chk("idle_reached", {31'd0, ifa.sout_valid | ifb.sout_valid}, 32'd0);
    chk("queues_drained", qa.size() + qb.size(), 32'd0);
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_ready"}, {31'd0, ifa.din_ready}, 32'd1);
    chk({tag, "_valid"}, {31'd0, ifa.sout_valid}, 32'd0);
    chk({tag, "_last"},  {31'd0, ifa.last}, 32'd0);
    chk({tag, "_busy"},  {31'd0, ifa.busy}, 32'd0);
  endtask

  initial begin
    vecs[0] = '{din: 4'b1101, ea: 4'b1101, eb: 4'b1011};
    vecs[1] = '{din: 4'b0110, ea: 4'b0110, eb: 4'b0110};
    vecs[2] = '{din: 4'b1010, ea: 4'b1010, eb: 4'b0101};
    vecs[3] = '{din: 4'b0011, ea: 4'b0011, eb: 4'b1100};
    vecs[4] = '{din: 4'b1001, ea: 4'b1001, eb: 4'b1001};
    vecs[5] = '{din: 4'b0111, ea: 4'b0111, eb: 4'b1110};

    reset_n = 1'b0;
    ifa.din_valid = 1'b0; ifa.din = '0;
    ifb.din_valid = 1'b0; ifb.din = '0;
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;
    @(posedge clock); #1;
    chk_idle("reset");
    chk("reset_sout", {31'd0, ifa.sout}, 32'd0);
    chk("reset_b_ready", {31'd0, ifb.din_ready}, 32'd1);

    // Single words from the table.
    foreach (vecs[i]) begin
      send(vecs[i].din, vecs[i].ea, vecs[i].eb, w);
      chk("first_bit_latency", {31'd0, ifa.sout_valid}, 32'd1);
      wait_idle();
      chk_idle("after_frame");
`ifdef PISO_PARITY_EN
      chk("a_sout_held", {31'd0, ifa.sout}, {31'd0, ^vecs[i].din});
      chk("b_sout_held", {31'd0, ifb.sout}, {31'd0, ^vecs[i].din});
`else
      chk("a_sout_held", {31'd0, ifa.sout}, {31'd0, vecs[i].ea[0]});
      chk("b_sout_held", {31'd0, ifb.sout}, {31'd0, vecs[i].eb[0]});
`endif
    end

    // Back-to-back: second word offered immediately, accepted on the last bit.
    max_run = 0;
    send(4'b1101, 4'b1101, 4'b1011, w);
    chk("b2b_first_wait", w, 32'd0);
    send(4'b0110, 4'b0110, 4'b0110, w);
    chk("b2b_second_wait", w, NB - 1);
    wait_idle();
    chk("b2b_gapless_run", max_run, 2 * NB);

    // Backpressure: offer during the second bit of a frame.
    send(4'b1101, 4'b1101, 4'b1011, w);
    @(posedge clock); #1;
    chk("bp_ready_low", {31'd0, ifa.din_ready}, 32'd0);
    send(4'b1010, 4'b1010, 4'b0101, w);
    chk("bp_wait", w, NB - 2);
    wait_idle();
    chk_idle("bp_end");

    // Reset mid-frame after two bits have gone out.
    send(4'b1001, 4'b1001, 4'b1001, w);
    @(negedge clock); #1;
    @(negedge clock); #1;
    reset_n = 1'b0;
    #1;
    chk_idle("mid_reset");
    chk("mid_reset_sout", {31'd0, ifa.sout}, 32'd0);
    qa.delete(); qb.delete();
    repeat (2) @(posedge clock);
    @(negedge clock) reset_n = 1'b1;
    @(posedge clock); #1;
    @(posedge clock); #1;
    chk("post_reset_no_resume", {31'd0, ifa.sout_valid}, 32'd0);
    send(4'b0011, 4'b0011, 4'b1100, w);
    wait_idle();
    chk_idle("post_reset_end");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
